// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP post-adder stage: operand select
// encodings, opmode bit positions and carry-source names.
package dsp_pkg;

    typedef enum logic [1:0] {
        X_ZERO = 2'b00,
        X_M    = 2'b01,
        X_P    = 2'b10,
        X_DAB  = 2'b11
    } xsel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'b00,
        Z_PCIN = 2'b01,
        Z_P    = 2'b10,
        Z_C    = 2'b11
    } zsel_e;

    localparam int OP_X_LSB = 0;
    localparam int OP_Z_LSB = 2;
    localparam int OP_CARRY = 5;
    localparam int OP_SUB   = 7;

    localparam CIS_OPMODE5 = "OPMODE5";
    localparam CIS_CARRYIN = "CARRYIN";

endpackage

// File: rtl/post_add_stage_if.sv
// Operand/result bundle of the post-adder stage.
// master drives operands and opmode; slave (the stage) returns M, P, PCOUT, CARRYOUT.
interface post_add_stage_if #(
    parameter int PW = 48,
    parameter int MW = 36
);
    logic signed [MW-1:0] outOfMul;
    logic [PW-1:0]        DAB;
    logic [PW-1:0]        C;
    logic [PW-1:0]        PCIN;
    logic [7:0]           opmode;
    logic                 CARRYIN;
    logic [MW-1:0]        M;
    logic [PW-1:0]        P;
    logic [PW-1:0]        PCOUT;
    logic                 CARRYOUT;

    modport master (
        output outOfMul, DAB, C, PCIN, opmode, CARRYIN,
        input  M, P, PCOUT, CARRYOUT
    );

    modport slave (
        input  outOfMul, DAB, C, PCIN, opmode, CARRYIN,
        output M, P, PCOUT, CARRYOUT
    );
endinterface

// File: rtl/pipe_delay.sv
// Clock-enabled shift chain with synchronous active-high reset.
// Ports: clk, rst (clears all stages, beats ce), ce, d_i, q_o. DEPTH=0 is a wire.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = ^{clk, rst, ce};
        assign q_o = d_i;
    end else begin : g_reg
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else if (ce) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end
endmodule

// File: rtl/post_add_stage.sv
// DSP post-adder: M pipeline, X/Z operand select, add/sub with carry, P register.
// Ports: clk, RSTM/RSTCARRYIN/RSTP resets, CEM/CECARRYIN/CEP enables, bus (slave).
module post_add_stage
    import dsp_pkg::*;
#(
    parameter int PW         = 48,
    parameter int MW         = 36,
    parameter int MDEPTH     = 1,
    parameter     CARRYINSEL = "OPMODE5",
    parameter int CARRYINREG = 1,
    parameter int PREG       = 1
) (
    input  logic clk,
    input  logic RSTM,
    input  logic RSTCARRYIN,
    input  logic RSTP,
    input  logic CEM,
    input  logic CECARRYIN,
    input  logic CEP,
    post_add_stage_if.slave bus
);
    // Any carry-source name other than CARRYIN falls back to opmode[5].
    localparam bit CIN_EXT = (CARRYINSEL == CIS_CARRYIN);

    logic [MW-1:0] m_q;
    logic          cin_d;
    logic          cin_q;
    logic [PW-1:0] x_d;
    logic [PW-1:0] z_d;
    logic [PW:0]   r_d;
    logic [PW:0]   pr_q;
    logic [PW-1:0] p_q;

    pipe_delay #(.WIDTH(MW), .DEPTH(MDEPTH)) u_mpipe (
        .clk (clk),
        .rst (RSTM),
        .ce  (CEM),
        .d_i (bus.outOfMul),
        .q_o (m_q)
    );

    assign cin_d = CIN_EXT ? bus.CARRYIN : bus.opmode[OP_CARRY];

    pipe_delay #(.WIDTH(1), .DEPTH(CARRYINREG)) u_cpipe (
        .clk (clk),
        .rst (RSTCARRYIN),
        .ce  (CECARRYIN),
        .d_i (cin_d),
        .q_o (cin_q)
    );

    always_comb begin
        x_d = '0;
        unique case (xsel_e'(bus.opmode[OP_X_LSB +: 2]))
            X_ZERO: x_d = '0;
            X_M:    x_d = {{(PW-MW){m_q[MW-1]}}, m_q};
            X_P:    x_d = p_q;
            X_DAB:  x_d = bus.DAB;
        endcase
    end

    always_comb begin
        z_d = '0;
        unique case (zsel_e'(bus.opmode[OP_Z_LSB +: 2]))
            Z_ZERO: z_d = '0;
            Z_PCIN: z_d = bus.PCIN;
            Z_P:    z_d = p_q;
            Z_C:    z_d = bus.C;
        endcase
    end

    // One extra bit so the top bit is carry on add and borrow on subtract.
    always_comb begin
        r_d = '0;
        if (bus.opmode[OP_SUB])
            r_d = {1'b0, z_d} - {1'b0, x_d} - {{PW{1'b0}}, cin_q};
        else
            r_d = {1'b0, z_d} + {1'b0, x_d} + {{PW{1'b0}}, cin_q};
    end

    pipe_delay #(.WIDTH(PW+1), .DEPTH(PREG)) u_ppipe (
        .clk (clk),
        .rst (RSTP),
        .ce  (CEP),
        .d_i (r_d),
        .q_o (pr_q)
    );

    assign p_q          = pr_q[PW-1:0];
    assign bus.P        = p_q;
    assign bus.PCOUT    = p_q;
    assign bus.CARRYOUT = pr_q[PW];
    assign bus.M        = m_q;
endmodule

// File: tb/tb_post_add_stage.sv
// Scoreboard bench for post_add_stage: default instance plus MDEPTH=0
// (external carry, unregistered) and MDEPTH=3 instances on shared stimulus.
module tb_post_add_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstm, rstc, rstp, cem, cec, cep;
    logic [35:0] mul;
    logic [47:0] dab, cop, pcin;
    logic [7:0]  opm;
    logic        cin;

    int unsigned cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    post_add_stage_if if_m ();
    post_add_stage_if if_0 ();
    post_add_stage_if if_3 ();

    assign if_m.outOfMul = mul; assign if_0.outOfMul = mul; assign if_3.outOfMul = mul;
    assign if_m.DAB = dab;      assign if_0.DAB = dab;      assign if_3.DAB = dab;
    assign if_m.C = cop;        assign if_0.C = cop;        assign if_3.C = cop;
    assign if_m.PCIN = pcin;    assign if_0.PCIN = pcin;    assign if_3.PCIN = pcin;
    assign if_m.opmode = opm;   assign if_0.opmode = opm;   assign if_3.opmode = opm;
    assign if_m.CARRYIN = cin;  assign if_0.CARRYIN = cin;  assign if_3.CARRYIN = cin;

    post_add_stage u_dut (
        .clk(clk), .RSTM(rstm), .RSTCARRYIN(rstc), .RSTP(rstp),
        .CEM(cem), .CECARRYIN(cec), .CEP(cep), .bus(if_m)
    );

    post_add_stage #(.MDEPTH(0), .CARRYINSEL("CARRYIN"), .CARRYINREG(0)) u_d0 (
        .clk(clk), .RSTM(rstm), .RSTCARRYIN(rstc), .RSTP(rstp),
        .CEM(cem), .CECARRYIN(cec), .CEP(cep), .bus(if_0)
    );

    post_add_stage #(.MDEPTH(3)) u_d3 (
        .clk(clk), .RSTM(rstm), .RSTCARRYIN(rstc), .RSTP(rstp),
        .CEM(cem), .CECARRYIN(cec), .CEP(cep), .bus(if_3)
    );

    typedef struct {
        int unsigned due;
        int          dut;
        string       tag;
        logic [47:0] p;
        logic        co;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int lat, input int dut, input string tag,
                        input logic [47:0] p, input logic co);
        exp_t e;
        e.due = cyc + lat; e.dut = dut; e.tag = tag; e.p = p; e.co = co;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                logic [47:0] p, pc;
                logic co;
                case (sb[i].dut)
                    1:       begin p = if_0.P; pc = if_0.PCOUT; co = if_0.CARRYOUT; end
                    2:       begin p = if_3.P; pc = if_3.PCOUT; co = if_3.CARRYOUT; end
                    default: begin p = if_m.P; pc = if_m.PCOUT; co = if_m.CARRYOUT; end
                endcase
                check(sb[i].tag, p, sb[i].p);
                check({sb[i].tag, "_pc"}, pc, sb[i].p);
                check({sb[i].tag, "_co"}, co, sb[i].co);
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                check({sb[i].tag, "_missed"}, 1, 0);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstm = 1; rstc = 1; rstp = 1;
        cem = 1; cec = 1; cep = 1;
        mul = 36'd9; dab = '0; cop = '0; pcin = '0;
        opm = 8'h01; cin = 0;
        tick(); tick();
        check("rst_m", if_m.M, 0);
        check("rst_p", if_m.P, 0);
        check("rst_pc", if_m.PCOUT, 0);
        check("rst_co", if_m.CARRYOUT, 0);
        check("rst_p_d0", if_0.P, 0);
        check("rst_m_d3", if_3.M, 0);

        // basic multiply path latency
        rstm = 0; rstc = 0; rstp = 0;
        mul = 36'd5;
        push(1, 0, "lat_e1", 48'd0, 0);
        push(2, 0, "lat_e2", 48'd5, 0);
        push(1, 1, "d0_lat", 48'd5, 0);
        push(3, 2, "d3_e3", 48'd0, 0);
        push(4, 2, "d3_e4", 48'd5, 0);
        drain();

        // external carry only seen by the CARRYIN-select instance
        cin = 1;
        push(1, 0, "cin_ign", 48'd5, 0);
        push(1, 1, "cin_ext", 48'd6, 0);
        push(1, 2, "cin_d3", 48'd5, 0);
        drain();
        cin = 0;

        // M hold on CEM=0, then reset beats enable
        cem = 0; mul = 36'd7;
        tick(); tick();
        check("m_hold", if_m.M, 5);
        check("m_hold_d3", if_3.M, 5);
        cem = 1;
        tick();
        check("m_load", if_m.M, 7);
        rstm = 1;
        tick();
        check("m_rst", if_m.M, 0);
        rstm = 0;

        // accumulate P += M, hold, reset mid-accumulation
        mul = 36'd3; opm = 8'h09; cep = 0; rstp = 1;
        push(1, 0, "acc_rst", 48'd0, 0);
        tick();
        rstp = 0; cep = 1;
        push(1, 0, "acc1", 48'd3, 0);
        push(2, 0, "acc2", 48'd6, 0);
        push(3, 0, "acc3", 48'd9, 0);
        push(4, 0, "acc4", 48'd12, 0);
        tick(); tick(); tick(); tick();
        cep = 0;
        push(1, 0, "hold1", 48'd12, 0);
        push(2, 0, "hold2", 48'd12, 0);
        tick(); tick();
        cep = 1; rstp = 1;
        push(1, 0, "rst_mid", 48'd0, 0);
        tick();
        rstp = 0;
        push(1, 0, "restart", 48'd3, 0);
        drain();

        // wrap-around with carry out
        cop = 48'hFFFF_FFFF_FFFF; dab = 48'd1; opm = 8'h0F;
        push(1, 0, "wrap", 48'd0, 1);
        drain();

        // subtract, carry from opmode[5] arrives one edge late
        cop = 48'd10; dab = 48'd3; opm = 8'hAF;
        push(1, 0, "sub_e1", 48'd7, 0);
        push(2, 0, "sub_e2", 48'd6, 0);
        drain();

        // borrow
        cop = 48'd0; dab = 48'd1; opm = 8'h8F;
        push(1, 0, "brw_e1", 48'hFFFF_FFFF_FFFE, 1);
        push(2, 0, "brw_e2", 48'hFFFF_FFFF_FFFF, 1);
        drain();

        // negative product is sign-extended
        mul = 36'hF_FFFF_FFFE; opm = 8'h01;
        push(1, 0, "sext_e1", 48'd3, 0);
        push(2, 0, "sext_e2", 48'hFFFF_FFFF_FFFE, 0);
        drain();

        // Z=PCIN, X=DAB, opmode[6]/[4] and CARRYIN ignored
        pcin = 48'd100; dab = 48'd23; opm = 8'h57; cin = 1;
        push(1, 0, "pcin", 48'd123, 0);
        push(2, 0, "pcin2", 48'd123, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
